// File: rtl/mips_port_io_if.sv
// rtl/mips_port_io_if.sv - processor data bus and external port signals of the MMIO responder
// slave is the responder's view, master is the processor/pin side.
interface mips_port_io_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Selected;
  logic [7:0]  PortIn;
  logic        PortInStrobe;
  logic [31:0] PortOut;
  logic        PortOutValid;
  logic        PortOutReady;

  modport slave (
    input  Address, WriteData, MemWrite, MemRead, PortIn, PortInStrobe, PortOutReady,
    output ReadData, Selected, PortOut, PortOutValid
  );

  modport master (
    output Address, WriteData, MemWrite, MemRead, PortIn, PortInStrobe, PortOutReady,
    input  ReadData, Selected, PortOut, PortOutValid
  );
endinterface

// File: rtl/mips_port_io.sv
// rtl/mips_port_io.sv - MIPS memory-mapped I/O responder with output FIFO and strobed input byte
// Four word registers: OUT_DATA (push / occupancy), IN_DATA, STATUS (W1C sticky errors), reserved.
module mips_port_io #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  mips_port_io_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_in_byte;
  logic          r_in_valid;
  logic          r_in_ovr;
  logic          r_out_ovf;
  logic          r_strobe_q;

  logic          w_sel;
  logic [1:0]    w_off;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_in_rd;
  logic          w_st_wr;
  logic          w_capture;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_sel      = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign w_off      = bus.Address[3:2];
  assign w_unused   = ^bus.Address[1:0];

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_pop      = w_valid & bus.PortOutReady;
  assign w_push_req = bus.MemWrite & w_sel & (w_off == 2'd0);
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;

  assign w_in_rd    = bus.MemRead & w_sel & (w_off == 2'd1);
  assign w_st_wr    = bus.MemWrite & w_sel & (w_off == 2'd2);
  assign w_capture  = bus.PortInStrobe & ~r_strobe_q;

  always_comb begin
    w_rdata = 32'h0;
    if (bus.MemRead && w_sel) begin
      case (w_off)
        2'd0:    w_rdata = {{(32-CW){1'b0}}, r_count};
        2'd1:    w_rdata = {24'h0, r_in_byte};
        2'd2:    w_rdata = {28'h0, r_out_ovf, r_in_ovr, w_full, r_in_valid};
        default: w_rdata = 32'h0;
      endcase
    end
  end

  assign bus.ReadData     = w_rdata;
  assign bus.Selected     = w_sel;
  assign bus.PortOutValid = w_valid;
  assign bus.PortOut      = w_valid ? r_mem[r_rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_in_byte  <= 8'h0;
      r_in_valid <= 1'b0;
      r_in_ovr   <= 1'b0;
      r_out_ovf  <= 1'b0;
      // Treat the strobe as already high so a level held across reset is not an edge.
      r_strobe_q <= 1'b1;
    end else begin
      r_strobe_q <= bus.PortInStrobe;

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_st_wr && bus.WriteData[3]) begin
        r_out_ovf <= 1'b0;
      end
      if (w_ovf_set) begin
        r_out_ovf <= 1'b1;
      end

      // Sticky set beats a same-cycle clear so an overrun is never lost.
      if (w_st_wr && bus.WriteData[2]) begin
        r_in_ovr <= 1'b0;
      end
      if (w_capture && r_in_valid && !w_in_rd) begin
        r_in_ovr <= 1'b1;
      end

      if (w_capture) begin
        r_in_byte  <= bus.PortIn;
        r_in_valid <= 1'b1;
      end else if (w_in_rd) begin
        r_in_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mips_port_io.sv
// tb/tb_mips_port_io.sv - self-checking bench for mips_port_io
// Directed scenarios with literal expectations, then randomized traffic against a queue-based model.
module tb_mips_port_io;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mips_port_io_if bus();

  mips_port_io #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue, flags are plain bits.
  logic [31:0] m_q[$];
  logic [7:0]  m_byte;
  logic        m_iv, m_ovr, m_ovf, m_sq, m_ok;
  logic        e_sel, e_cap, e_ird;
  logic [31:0] e_rd;

  initial m_ok = 1'b0;

  always @(negedge clk) begin
    e_sel = (bus.Address[31:4] == BASE[31:4]);
    e_rd  = 32'h0;
    if (bus.MemRead && e_sel) begin
      case (bus.Address[3:2])
        2'd0: e_rd = 32'(m_q.size());
        2'd1: e_rd = {24'h0, m_byte};
        2'd2: e_rd = {28'h0, m_ovf, m_ovr, (m_q.size() == DEPTH), m_iv};
        default: e_rd = 32'h0;
      endcase
    end
    if (m_ok) begin
      chk("Selected", {31'h0, bus.Selected}, {31'h0, e_sel});
      chk("ReadData", bus.ReadData, e_rd);
      chk("PortOutValid", {31'h0, bus.PortOutValid}, {31'h0, (m_q.size() != 0)});
      chk("PortOut", bus.PortOut, (m_q.size() != 0) ? m_q[0] : 32'h0);
    end
    // Advance the model to the state after the coming rising edge.
    if (!reset) begin
      m_q.delete();
      m_byte = 8'h0;
      m_iv = 1'b0; m_ovr = 1'b0; m_ovf = 1'b0; m_sq = 1'b1;
      m_ok = 1'b1;
    end else begin
      if (m_q.size() != 0 && bus.PortOutReady) void'(m_q.pop_front());
      if (bus.MemWrite && e_sel && bus.Address[3:2] == 2'd0) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.WriteData);
        else m_ovf = 1'b1;
      end
      if (bus.MemWrite && e_sel && bus.Address[3:2] == 2'd2) begin
        if (bus.WriteData[3]) m_ovf = 1'b0;
        if (bus.WriteData[2]) m_ovr = 1'b0;
      end
      e_cap = bus.PortInStrobe && !m_sq;
      e_ird = bus.MemRead && e_sel && bus.Address[3:2] == 2'd1;
      if (e_cap) begin
        if (m_iv && !e_ird) m_ovr = 1'b1;
        m_byte = bus.PortIn;
        m_iv = 1'b1;
      end else if (e_ird) begin
        m_iv = 1'b0;
      end
      m_sq = bus.PortInStrobe;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.Address = addr; bus.WriteData = data; bus.MemWrite = 1'b1;
    tick();
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.Address = addr; bus.MemRead = 1'b1;
    #1;
    chk(name, bus.ReadData, exp);
    tick();
    bus.MemRead = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_seq [4];
  int          r;

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0;
    bus.Address = 32'h0; bus.WriteData = 32'h0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    bus.PortIn = 8'h0; bus.PortInStrobe = 1'b0; bus.PortOutReady = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("reset_valid", {31'h0, bus.PortOutValid}, 32'h0);
    chk("reset_out", bus.PortOut, 32'h0);
    rd_expect("reset_status", BASE + 8, 32'h0);

    wr(BASE, 32'hDEADBEEF);
    #1;
    chk("store_valid", {31'h0, bus.PortOutValid}, 32'h1);
    chk("store_out", bus.PortOut, 32'hDEADBEEF);
    rd_expect("store_count", BASE, 32'h1);
    bus.PortOutReady = 1'b1; tick(); bus.PortOutReady = 1'b0;

    for (int i = 1; i <= 5; i++) wr(BASE, 32'(i));
    rd_expect("full_count", BASE, 32'h4);
    rd_expect("full_status", BASE + 8, 32'hA);
    bus.PortOutReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", bus.PortOut, 32'(i));
      tick();
    end
    chk("drain_empty", {31'h0, bus.PortOutValid}, 32'h0);
    bus.PortOutReady = 1'b0;
    wr(BASE + 8, 32'h8);
    rd_expect("ovf_cleared", BASE + 8, 32'h0);

    for (int i = 0; i < 4; i++) wr(BASE, 32'h10 + 32'(i));
    bus.PortOutReady = 1'b1;
    wr(BASE, 32'h99);
    bus.PortOutReady = 1'b0;
    rd_expect("pushpop_status", BASE + 8, 32'h2);
    rd_expect("pushpop_count", BASE + 4 - 4, 32'h4);
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h12; exp_seq[2] = 32'h13; exp_seq[3] = 32'h99;
    bus.PortOutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pushpop_order", bus.PortOut, exp_seq[i]);
      tick();
    end
    chk("pushpop_empty", {31'h0, bus.PortOutValid}, 32'h0);
    bus.PortOutReady = 1'b0;

    bus.PortIn = 8'hA5; bus.PortInStrobe = 1'b1; tick(); bus.PortInStrobe = 1'b0;
    rd_expect("in_status_set", BASE + 8, 32'h1);
    rd_expect("in_data", BASE + 4, 32'hA5);
    rd_expect("in_status_clr", BASE + 8, 32'h0);
    bus.PortIn = 8'h3C; bus.PortInStrobe = 1'b1; tick();
    bus.PortIn = 8'h77;
    repeat (9) tick();
    bus.PortInStrobe = 1'b0;
    rd_expect("held_status", BASE + 8, 32'h1);
    rd_expect("held_data", BASE + 4, 32'h3C);

    bus.PortIn = 8'h11; bus.PortInStrobe = 1'b1; tick(); bus.PortInStrobe = 1'b0; tick();
    bus.PortIn = 8'h22; bus.PortInStrobe = 1'b1; tick(); bus.PortInStrobe = 1'b0;
    rd_expect("ovr_status", BASE + 8, 32'h5);
    wr(BASE + 8, 32'h4);
    rd_expect("ovr_cleared", BASE + 8, 32'h1);
    rd_expect("ovr_data", BASE + 4, 32'h22);

    for (int i = 0; i < 3; i++) wr(BASE, 32'hA0 + 32'(i));
    bus.PortIn = 8'h5A; bus.PortInStrobe = 1'b1; bus.PortOutReady = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1; bus.PortOutReady = 1'b0;
    #1;
    chk("rst_mid_valid", {31'h0, bus.PortOutValid}, 32'h0);
    chk("rst_mid_out", bus.PortOut, 32'h0);
    rd_expect("rst_mid_status", BASE + 8, 32'h0);
    repeat (3) tick();
    rd_expect("rst_strobe_held", BASE + 8, 32'h0);
    bus.PortInStrobe = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 249) != 0);
      r = $urandom_range(0, 19);
      bus.MemWrite = (r < 7) || (r == 19);
      bus.MemRead  = (r >= 7 && r < 14) || (r == 19);
      bus.Address  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : BASE + 32'($urandom_range(0, 15));
      bus.WriteData = 32'($urandom);
      bus.PortIn = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.PortInStrobe = ~bus.PortInStrobe;
      bus.PortOutReady = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 1'b1; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
